dbus_mem_access: RTL and testbench

- MEM-stage data-memory access unit: takes one load/store per instruction from the MEM stage and drives the data bus request/response handshake.
- Returns the aligned, extended load result.
- Generates Dwait, the stall consumed by the MEM/WB pipeline register and the hazard logic; it is the producing end of that stall interface.
- One outstanding transaction at most.

---
 rtl/dbus_mem_access_pkg.sv | 53 +++++
 rtl/dbus_mem_access_align.sv | 57 +++++
 rtl/dbus_mem_access.sv | 140 ++++++++++++++
 tb/tb_dbus_mem_access.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_mem_access_pkg.sv
// ============================================================================
// Module   : dbus_mem_access_pkg
// Brief    : Shared types for the MEM-stage data-bus access unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dbus_mem_access_pkg;

    localparam int C_DBUS_ADDR_W = 64;
    localparam int C_DBUS_DATA_W = 64;
    localparam int C_DBUS_STRB_W = 8;

    typedef enum logic [2:0] {
        MSIZE_BYTE  = 3'd0,
        MSIZE_HALF  = 3'd1,
        MSIZE_WORD  = 3'd2,
        MSIZE_DWORD = 3'd3
    } msize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } dbus_state_t;

    typedef struct packed {
        logic [C_DBUS_ADDR_W-1:0] addr;
        msize_t                   size;
        logic [C_DBUS_STRB_W-1:0] strobe;
        logic [C_DBUS_DATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic                     addr_ok;
        logic                     data_ok;
        logic [C_DBUS_DATA_W-1:0] data;
    } dbus_resp_t;

    // Low address bits that must be zero for an access of the given size
    function automatic logic [2:0] size_mask(input logic [2:0] size);
        case (size)
            MSIZE_BYTE: size_mask = 3'b000;
            MSIZE_HALF: size_mask = 3'b001;
            MSIZE_WORD: size_mask = 3'b011;
            default:    size_mask = 3'b111;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/dbus_mem_access_align.sv
// ============================================================================
// Module   : mem_align
// Brief    : Store lane shift/strobe generation and load extract/extend.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_align
    import dbus_mem_access_pkg::*;
(
    input  logic [2:0]  st_offset,
    input  logic [2:0]  st_size,
    input  logic [63:0] st_wdata,
    output logic [7:0]  st_strobe,
    output logic [63:0] st_data,
    input  logic [2:0]  ld_offset,
    input  logic [2:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic        ld_is_store,
    input  logic [63:0] ld_raw,
    output logic [63:0] ld_result
);

    logic [7:0]  w_base_strobe;
    logic [63:0] w_ld_shifted;

    always_comb begin
        case (st_size)
            MSIZE_BYTE: w_base_strobe = 8'h01;
            MSIZE_HALF: w_base_strobe = 8'h03;
            MSIZE_WORD: w_base_strobe = 8'h0F;
            default:    w_base_strobe = 8'hFF;
        endcase
    end

    assign st_strobe    = w_base_strobe << st_offset;
    assign st_data      = st_wdata << {st_offset, 3'b000};
    assign w_ld_shifted = ld_raw >> {ld_offset, 3'b000};

    always_comb begin
        ld_result = 64'd0;
        if (!ld_is_store) begin
            case (ld_size)
                MSIZE_BYTE: ld_result = ld_unsigned ? {56'd0, w_ld_shifted[7:0]}
                                                    : {{56{w_ld_shifted[7]}}, w_ld_shifted[7:0]};
                MSIZE_HALF: ld_result = ld_unsigned ? {48'd0, w_ld_shifted[15:0]}
                                                    : {{48{w_ld_shifted[15]}}, w_ld_shifted[15:0]};
                MSIZE_WORD: ld_result = ld_unsigned ? {32'd0, w_ld_shifted[31:0]}
                                                    : {{32{w_ld_shifted[31]}}, w_ld_shifted[31:0]};
                default:    ld_result = w_ld_shifted;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/dbus_mem_access.sv
// ============================================================================
// Module   : dbus_mem_access
// Brief    : MEM-stage load/store unit driving the data-bus handshake and Dwait.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dbus_mem_access
    import dbus_mem_access_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              Iwait,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [7:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data,
    output logic              Dwait,
    output logic [DATA_W-1:0] rdata,
    output logic              misaligned
);

    dbus_state_t r_state;
    dbus_state_t w_next;
    dbus_req_t   r_req;
    logic        r_unsigned;
    logic        r_is_store;
    logic [63:0] r_rdata;

    dbus_resp_t  w_resp;
    logic        w_start;
    logic        w_capture;
    logic [7:0]  w_st_strobe;
    logic [63:0] w_st_data;
    logic [63:0] w_ld_result;

    assign w_resp     = '{addr_ok: dresp_addr_ok, data_ok: dresp_data_ok, data: dresp_data};
    assign misaligned = req_valid & (|(req_addr[2:0] & size_mask(req_size)));

    mem_align u_mem_align (
        .st_offset   (req_addr[2:0]),
        .st_size     (req_size),
        .st_wdata    (req_wdata),
        .st_strobe   (w_st_strobe),
        .st_data     (w_st_data),
        .ld_offset   (r_req.addr[2:0]),
        .ld_size     (r_req.size),
        .ld_unsigned (r_unsigned),
        .ld_is_store (r_is_store),
        .ld_raw      (w_resp.data),
        .ld_result   (w_ld_result)
    );

    // A flushed instruction (req_valid dropped) still finishes its bus beat
    // but returns to IDLE without publishing a result.
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid && !misaligned) begin
                    w_next  = ADDR;
                    w_start = 1'b1;
                end
            end
            ADDR: begin
                if (w_resp.addr_ok) begin
                    if (w_resp.data_ok) begin
                        w_capture = req_valid;
                        if (req_valid) w_next = DONE;
                        else           w_next = IDLE;
                    end else begin
                        w_next = DATA;
                    end
                end
            end
            DATA: begin
                if (w_resp.data_ok) begin
                    w_capture = req_valid;
                    if (req_valid) w_next = DONE;
                    else           w_next = IDLE;
                end
            end
            DONE: begin
                if (!Iwait) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_req      <= '0;
            r_unsigned <= 1'b0;
            r_is_store <= 1'b0;
            r_rdata    <= 64'd0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_req.addr   <= req_addr;
                r_req.size   <= msize_t'(req_size);
                r_req.strobe <= req_is_store ? w_st_strobe : 8'h00;
                r_req.data   <= w_st_data;
                r_unsigned   <= req_unsigned;
                r_is_store   <= req_is_store;
            end
            if (w_capture) begin
                r_rdata <= w_ld_result;
            end
        end
    end

    assign dreq_valid  = (r_state == ADDR);
    assign dreq_addr   = r_req.addr;
    assign dreq_size   = r_req.size;
    assign dreq_strobe = r_req.strobe;
    assign dreq_data   = r_req.data;
    assign rdata       = r_rdata;
    assign Dwait       = (r_state == ADDR) || (r_state == DATA) ||
                         ((r_state == IDLE) && req_valid && !misaligned);

endmodule

`default_nettype wire

// File: tb/tb_dbus_mem_access.sv
// ============================================================================
// Module   : tb_dbus_mem_access
// Brief    : Directed self-checking bench for dbus_mem_access.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dbus_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_is_store, req_unsigned, Iwait;
    logic [63:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        dreq_valid;
    logic [63:0] dreq_addr, dreq_data;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [63:0] dresp_data;
    logic        Dwait, misaligned;
    logic [63:0] rdata;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dbus_mem_access dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_is_store  (req_is_store),
        .req_addr      (req_addr),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_wdata     (req_wdata),
        .Iwait         (Iwait),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .Dwait         (Dwait),
        .rdata         (rdata),
        .misaligned    (misaligned)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic v, input logic st, input logic [63:0] a,
                           input logic [2:0] sz, input logic uns, input logic [63:0] wd);
        req_valid    = v;
        req_is_store = st;
        req_addr     = a;
        req_size     = sz;
        req_unsigned = uns;
        req_wdata    = wd;
    endtask

    // Inputs change 2 time units after the edge; checks run 2 units later.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Load whose bus gives addr_ok and data_ok together in the first ADDR cycle
    task automatic do_load(input string tag, input logic [63:0] a, input logic [2:0] sz,
                           input logic uns, input logic [63:0] bus, input logic [63:0] exp);
        next_cycle();
        set_req(1'b1, 1'b0, a, sz, uns, 64'd0);
        #2;
        chk({tag, "_idle_dwait"}, 64'(Dwait), 64'd1);
        chk({tag, "_idle_dreq_valid"}, 64'(dreq_valid), 64'd0);
        next_cycle();
        dresp_addr_ok = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = bus;
        #2;
        chk({tag, "_addr_dreq_valid"}, 64'(dreq_valid), 64'd1);
        chk({tag, "_addr_dreq_addr"}, dreq_addr, a);
        chk({tag, "_addr_strobe"}, 64'(dreq_strobe), 64'd0);
        chk({tag, "_addr_dwait"}, 64'(Dwait), 64'd1);
        next_cycle();
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = 64'd0;
        req_valid     = 1'b0;
        #2;
        chk({tag, "_done_dwait"}, 64'(Dwait), 64'd0);
        chk({tag, "_done_rdata"}, rdata, exp);
    endtask

    initial begin
        reset = 1'b1;
        Iwait = 1'b0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data = 64'd0;
        set_req(1'b0, 1'b0, 64'd0, 3'd0, 1'b0, 64'd0);

        // Reset state
        next_cycle();
        chk("rst_dwait", 64'(Dwait), 64'd0);
        chk("rst_dreq_valid", 64'(dreq_valid), 64'd0);
        chk("rst_dreq_addr", dreq_addr, 64'd0);
        chk("rst_dreq_strobe", 64'(dreq_strobe), 64'd0);
        chk("rst_dreq_data", dreq_data, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_misaligned", 64'(misaligned), 64'd0);
        reset = 1'b0;

        // Aligned LD, then signed and unsigned LB at byte 3
        do_load("ld", 64'h8000_0010, 3'd3, 1'b0, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788);
        do_load("lb", 64'h8000_0013, 3'd0, 1'b0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lbu", 64'h8000_0013, 3'd0, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);

        // SH at byte 6, addr_ok after one wait cycle, data_ok two cycles later
        next_cycle();
        set_req(1'b1, 1'b1, 64'h8000_0006, 3'd1, 1'b0, 64'h0000_0000_0000_ABCD);
        #2;
        chk("sh_idle_dwait", 64'(Dwait), 64'd1);
        chk("sh_idle_dreq_valid", 64'(dreq_valid), 64'd0);
        next_cycle();
        #2;
        chk("sh_addr_dreq_valid", 64'(dreq_valid), 64'd1);
        chk("sh_strobe", 64'(dreq_strobe), 64'h0000_0000_0000_00C0);
        chk("sh_data", dreq_data, 64'hABCD_0000_0000_0000);
        chk("sh_size", 64'(dreq_size), 64'd1);
        next_cycle();
        dresp_addr_ok = 1'b1;
        #2;
        chk("sh_addr2_dreq_valid", 64'(dreq_valid), 64'd1);
        next_cycle();
        dresp_addr_ok = 1'b0;
        #2;
        chk("sh_data_dreq_valid", 64'(dreq_valid), 64'd0);
        chk("sh_data_dwait", 64'(Dwait), 64'd1);
        next_cycle();
        dresp_data_ok = 1'b1;
        dresp_data    = 64'hDEAD_BEEF_DEAD_BEEF;
        #2;
        chk("sh_dataok_dwait", 64'(Dwait), 64'd1);
        next_cycle();
        dresp_data_ok = 1'b0;
        req_valid     = 1'b0;
        #2;
        chk("sh_done_dwait", 64'(Dwait), 64'd0);
        chk("sh_done_rdata", rdata, 64'd0);

        // Misaligned LW: no bus activity, no stall
        next_cycle();
        set_req(1'b1, 1'b0, 64'h8000_0002, 3'd2, 1'b0, 64'd0);
        #2;
        chk("lw_mis_flag", 64'(misaligned), 64'd1);
        chk("lw_mis_dwait", 64'(Dwait), 64'd0);
        next_cycle();
        #2;
        chk("lw_mis_dreq_valid", 64'(dreq_valid), 64'd0);
        chk("lw_mis_dwait2", 64'(Dwait), 64'd0);
        req_valid = 1'b0;
        #1;
        chk("lw_mis_novalid", 64'(misaligned), 64'd0);

        // LH completes under Iwait; held in DONE for three cycles
        next_cycle();
        set_req(1'b1, 1'b0, 64'h8000_0004, 3'd1, 1'b0, 64'd0);
        next_cycle();
        dresp_addr_ok = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h0000_8001_0000_0000;
        Iwait         = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            dresp_addr_ok = 1'b0;
            dresp_data_ok = 1'b0;
            dresp_data    = 64'hFFFF_FFFF_FFFF_FFFF;
            #2;
            chk("iwait_done_dwait", 64'(Dwait), 64'd0);
            chk("iwait_done_rdata", rdata, 64'hFFFF_FFFF_FFFF_8001);
        end
        next_cycle();
        Iwait = 1'b0;
        #2;
        chk("iwait_release_dwait", 64'(Dwait), 64'd0);
        next_cycle();
        #1;
        chk("iwait_idle_dwait", 64'(Dwait), 64'd1);
        req_valid = 1'b0;
        #1;
        chk("iwait_idle_dwait_off", 64'(Dwait), 64'd0);

        // Asynchronous reset while waiting in DATA
        next_cycle();
        set_req(1'b1, 1'b0, 64'h8000_0020, 3'd3, 1'b0, 64'd0);
        next_cycle();
        dresp_addr_ok = 1'b1;
        next_cycle();
        dresp_addr_ok = 1'b0;
        #2;
        chk("rstmid_data_dreq_valid", 64'(dreq_valid), 64'd0);
        chk("rstmid_data_dwait", 64'(Dwait), 64'd1);
        #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("rstmid_rdata", rdata, 64'd0);
        chk("rstmid_dreq_addr", dreq_addr, 64'd0);
        chk("rstmid_dwait", 64'(Dwait), 64'd0);
        next_cycle();
        reset         = 1'b0;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'hFFFF_FFFF_FFFF_FFFF;
        next_cycle();
        dresp_data_ok = 1'b0;
        #2;
        chk("stray_rdata", rdata, 64'd0);
        chk("stray_dwait", 64'(Dwait), 64'd0);
        chk("stray_dreq_valid", 64'(dreq_valid), 64'd0);

        // Flush: request withdrawn while in ADDR, result discarded
        next_cycle();
        set_req(1'b1, 1'b0, 64'h8000_0040, 3'd3, 1'b0, 64'd0);
        next_cycle();
        req_valid = 1'b0;
        #2;
        chk("flush_dreq_valid", 64'(dreq_valid), 64'd1);
        chk("flush_dwait", 64'(Dwait), 64'd1);
        dresp_addr_ok = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h0000_0000_0000_1234;
        next_cycle();
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        set_req(1'b1, 1'b0, 64'h8000_0048, 3'd3, 1'b0, 64'd0);
        #2;
        chk("flush_idle_dwait", 64'(Dwait), 64'd1);
        chk("flush_rdata", rdata, 64'd0);
        req_valid = 1'b0;
        #1;
        chk("flush_idle_dwait_off", 64'(Dwait), 64'd0);

        next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
